bus_datapath: RTL and testbench

Parametrised successor to the group CPU's bus datapath: a single shared bus connecting a register file of configurable width and depth with PC, IR, MAR, MDR, HI, LO, Y and a double-width Z register. The ALU adds iterative multiply and divide sequencers, so MUL/DIV execute over multiple cycles with a busy/done handshake to the control unit. All transfers are driven by control-unit strobes, one bus source per cycle.

---
 rtl/bus_datapath.sv | 250 +++++++++++++++++++++++++
 tb/tb_bus_datapath.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datapath.sv
// Shared-bus CPU datapath: register file, PC/IR/MAR/MDR/HI/LO/Y/Z, ALU.
// MUL/DIV run on an iterative sequencer; DATAPATH_SIGNED_MULDIV_EN selects signed MUL/DIV.
module bus_datapath #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  reg_in_en,
    input  logic                  reg_out_en,
    input  logic [SEL_W-1:0]      reg_in_sel,
    input  logic [SEL_W-1:0]      reg_out_sel,
    input  logic                  PCin,
    input  logic                  PCout,
    input  logic                  IncPC,
    input  logic                  IRin,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  MDRout,
    input  logic                  MDRread,
    input  logic                  HIin,
    input  logic                  HIout,
    input  logic                  LOin,
    input  logic                  LOout,
    input  logic                  Yin,
    input  logic                  Zin,
    input  logic                  Zhighout,
    input  logic                  Zlowout,
    input  logic                  InPortout,
    input  logic [3:0]            alu_op,
    input  logic [DATA_W-1:0]     MDatain,
    input  logic [DATA_W-1:0]     inport_data,
    output logic [DATA_W-1:0]     bus_out,
    output logic [DATA_W-1:0]     ir_out,
    output logic [DATA_W-1:0]     mar_out,
    output logic [2*DATA_W-1:0]   z_out,
    output logic                  busy,
    output logic                  done
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   pc, ir, mar, mdr, hi, lo, y;
    logic [2*DATA_W-1:0] z;
    logic [DATA_W-1:0]   bus;
    logic [DATA_W-1:0]   alu_res;
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] rot_r, rot_l;
    logic                is_muldiv;

    state_t              state, state_nx;
    logic                start, finish;
    logic [CNT_W-1:0]    cnt;

    logic                op_div, neg_q, neg_r, div0;
    logic [DATA_W-1:0]   a_raw, opd, acc, lsw;
    logic                sa, sb;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, div_sh, div_tr;
    logic                div_ok;
    logic [DATA_W-1:0]   acc_nx, lsw_nx;
    logic [2*DATA_W-1:0] prod, mul_res, div_res, md_res;
    logic [DATA_W-1:0]   quo, rem;

    assign bus_out   = bus;
    assign ir_out    = ir;
    assign mar_out   = mar;
    assign z_out     = z;
    assign busy      = (state == RUN);
    assign sh        = bus[SH_W-1:0];
    assign is_muldiv = (alu_op == 4'd11) || (alu_op == 4'd12);

`ifdef DATAPATH_SIGNED_MULDIV_EN
    assign sa = y[DATA_W-1];
    assign sb = bus[DATA_W-1];
`else
    assign sa = 1'b0;
    assign sb = 1'b0;
`endif

    assign mag_a = sa ? -y : y;
    assign mag_b = sb ? -bus : bus;

    // Bus source select: fixed priority, zero when nothing drives
    always_comb begin
        bus = '0;
        if (reg_out_en)     bus = regs[reg_out_sel];
        else if (PCout)     bus = pc;
        else if (MDRout)    bus = mdr;
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (Zhighout)  bus = z[2*DATA_W-1:DATA_W];
        else if (Zlowout)   bus = z[DATA_W-1:0];
        else if (InPortout) bus = inport_data;
    end

    // Single-cycle ALU: A is Y, B is the bus
    always_comb begin
        rot_r   = {y, y} >> sh;
        rot_l   = {y, y} << sh;
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = y + bus;
            4'd1:    alu_res = y - bus;
            4'd2:    alu_res = y & bus;
            4'd3:    alu_res = y | bus;
            4'd4:    alu_res = y >> sh;
            4'd5:    alu_res = $signed(y) >>> sh;
            4'd6:    alu_res = y << sh;
            4'd7:    alu_res = rot_r[DATA_W-1:0];
            4'd8:    alu_res = rot_l[2*DATA_W-1:DATA_W];
            4'd9:    alu_res = -bus;
            4'd10:   alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    // One MUL/DIV iteration plus sign fix-up of the final result
    always_comb begin
        mul_sum = {1'b0, acc} + (lsw[0] ? {1'b0, opd} : '0);
        div_sh  = {acc, lsw[DATA_W-1]};
        div_tr  = div_sh - {1'b0, opd};
        div_ok  = !div_tr[DATA_W];
        if (op_div) begin
            acc_nx = div_ok ? div_tr[DATA_W-1:0] : div_sh[DATA_W-1:0];
            lsw_nx = {lsw[DATA_W-2:0], div_ok};
        end else begin
            acc_nx = mul_sum[DATA_W:1];
            lsw_nx = {mul_sum[0], lsw[DATA_W-1:1]};
        end
        prod    = {acc_nx, lsw_nx};
        mul_res = neg_q ? -prod : prod;
        quo     = neg_q ? -lsw_nx : lsw_nx;
        rem     = neg_r ? -acc_nx : acc_nx;
        div_res = div0 ? {a_raw, {DATA_W{1'b1}}} : {rem, quo};
        md_res  = op_div ? div_res : mul_res;
    end

    // Sequencer next state: start on Zin with MUL/DIV, finish after DATA_W steps
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (Zin && is_muldiv) begin
                    state_nx = RUN;
                    start    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    finish   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clock) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    // Sequencer operands, partial results and iteration counter
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            a_raw  <= '0;
            opd    <= '0;
            acc    <= '0;
            lsw    <= '0;
        end else if (start) begin
            cnt    <= '0;
            op_div <= (alu_op == 4'd12);
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= (bus == '0);
            a_raw  <= y;
            acc    <= '0;
            opd    <= (alu_op == 4'd12) ? mag_b : mag_a;
            lsw    <= (alu_op == 4'd12) ? mag_a : mag_b;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_nx;
            lsw <= lsw_nx;
        end
    end

    // Z register and completion pulse
    always_ff @(posedge clock) begin
        if (clear) begin
            z    <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish)
                z <= md_res;
            else if (Zin && !busy && !is_muldiv)
                z <= {{DATA_W{1'b0}}, alu_res};
        end
    end

    // General register file
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_in_en) begin
            regs[reg_in_sel] <= bus;
        end
    end

    // Special registers loaded from the bus
    always_ff @(posedge clock) begin
        if (clear) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
            y   <= '0;
        end else begin
            if (PCin)       pc <= bus;
            else if (IncPC) pc <= pc + DATA_W'(1);
            if (IRin)  ir  <= bus;
            if (MARin) mar <= bus;
            if (MDRin) mdr <= MDRread ? MDatain : bus;
            if (HIin)  hi  <= bus;
            if (LOin)  lo  <= bus;
            if (Yin)   y   <= bus;
        end
    end

endmodule

// File: tb/tb_bus_datapath.sv
// Randomised self-checking bench for bus_datapath with a behavioural model.
// Honours DATAPATH_SIGNED_MULDIV_EN the same way as the design.
module tb_bus_datapath;

    logic        clock;
    logic        clear;
    logic        reg_in_en, reg_out_en;
    logic [3:0]  reg_in_sel, reg_out_sel;
    logic        PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout, MDRread;
    logic        HIin, HIout, LOin, LOout, Yin, Zin, Zhighout, Zlowout;
    logic        InPortout;
    logic [3:0]  alu_op;
    logic [31:0] MDatain, inport_data;
    logic [31:0] bus_out, ir_out, mar_out;
    logic [63:0] z_out;
    logic        busy, done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
    logic [63:0] m_z, m_pend;
    int          m_left;
    bit          m_done;

    bus_datapath dut (
        .clock(clock), .clear(clear),
        .reg_in_en(reg_in_en), .reg_out_en(reg_out_en),
        .reg_in_sel(reg_in_sel), .reg_out_sel(reg_out_sel),
        .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .MDRread(MDRread),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .InPortout(InPortout), .alu_op(alu_op),
        .MDatain(MDatain), .inport_data(inport_data),
        .bus_out(bus_out), .ir_out(ir_out), .mar_out(mar_out),
        .z_out(z_out), .busy(busy), .done(done)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_bus();
        if (reg_out_en) return m_r[reg_out_sel];
        if (PCout)      return m_pc;
        if (MDRout)     return m_mdr;
        if (HIout)      return m_hi;
        if (LOout)      return m_lo;
        if (Zhighout)   return m_z[63:32];
        if (Zlowout)    return m_z[31:0];
        if (InPortout)  return inport_data;
        return 32'd0;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int s;
        s = int'(b[4:0]);
        r = a;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a >> s;
            4'd5: r = $signed(a) >>> s;
            4'd6: r = a << s;
            4'd7: for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
            4'd8: for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
            4'd9: r = 32'd0 - b;
            4'd10: r = ~b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] muldiv_ref(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint qq, rr;
`ifdef DATAPATH_SIGNED_MULDIV_EN
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 4'd11) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        qq = sa / sb;
        rr = sa % sb;
`else
        longint unsigned ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 4'd11) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        qq = longint'(ua / ub);
        rr = longint'(ua % ub);
`endif
        return {rr[31:0], qq[31:0]};
    endfunction

    // Behavioural model: advance one clock edge from the current inputs
    always @(posedge clock) begin
        logic [31:0] b, ya;
        b  = exp_bus();
        ya = m_y;
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
            m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
            m_hi = 0; m_lo = 0; m_y = 0; m_z = 0;
            m_left = 0; m_done = 0;
        end else begin
            if (reg_in_en) m_r[reg_in_sel] = b;
            if (PCin)       m_pc = b;
            else if (IncPC) m_pc = m_pc + 1;
            if (IRin)  m_ir = b;
            if (MARin) m_mar = b;
            if (MDRin) m_mdr = MDRread ? MDatain : b;
            if (HIin)  m_hi = b;
            if (LOin)  m_lo = b;
            if (Yin)   m_y = b;
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_z = m_pend;
                    m_done = 1;
                end
            end else if (Zin) begin
                if (alu_op == 4'd11 || alu_op == 4'd12) begin
                    m_pend = muldiv_ref(alu_op, ya, b);
                    m_left = 32;
                end else begin
                    m_z = {32'd0, alu_ref(alu_op, ya, b)};
                end
            end
        end
    end

    // Compare DUT against the model every cycle
    always @(negedge clock) begin
        if (chk_en) begin
            chk("bus", {32'd0, bus_out}, {32'd0, exp_bus()});
            chk("ir", {32'd0, ir_out}, {32'd0, m_ir});
            chk("mar", {32'd0, mar_out}, {32'd0, m_mar});
            chk("z", z_out, m_z);
            chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
            chk("done", {63'd0, done}, {63'd0, m_done});
        end
    end

    task automatic idle();
        clear = 0; reg_in_en = 0; reg_out_en = 0;
        reg_in_sel = 0; reg_out_sel = 0;
        PCin = 0; PCout = 0; IncPC = 0; IRin = 0; MARin = 0;
        MDRin = 0; MDRout = 0; MDRread = 0; HIin = 0; HIout = 0;
        LOin = 0; LOout = 0; Yin = 0; Zin = 0; Zhighout = 0;
        Zlowout = 0; InPortout = 0; alu_op = 0;
        MDatain = 0; inport_data = 0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic drive_in(input logic [31:0] v);
        InPortout = 1;
        inport_data = v;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
        idle(); drive_in(a); Yin = 1;
        cyc();
        idle(); drive_in(b); Zin = 1; alu_op = op;
        cyc();
        idle();
    endtask

    task automatic watch(input int maxc, input int poke,
                         output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        for (int k = 0; k < maxc; k++) begin
            idle();
            if (k == poke) begin
                drive_in(32'd77);
                Zin = 1;
                alu_op = 4'd0;
            end
            @(negedge clock);
            if (busy) nbusy++;
            if (done) ndone++;
            cyc();
        end
        idle();
    endtask

    task automatic randomize_inputs();
        clear       = ($urandom_range(0, 150) == 0);
        reg_in_en   = ($urandom_range(0, 4) == 0);
        reg_out_en  = ($urandom_range(0, 4) == 0);
        reg_in_sel  = 4'($urandom_range(0, 15));
        reg_out_sel = 4'($urandom_range(0, 15));
        PCin        = ($urandom_range(0, 7) == 0);
        PCout       = ($urandom_range(0, 6) == 0);
        IncPC       = ($urandom_range(0, 3) == 0);
        IRin        = ($urandom_range(0, 5) == 0);
        MARin       = ($urandom_range(0, 5) == 0);
        MDRin       = ($urandom_range(0, 5) == 0);
        MDRout      = ($urandom_range(0, 6) == 0);
        MDRread     = ($urandom_range(0, 1) == 0);
        HIin        = ($urandom_range(0, 5) == 0);
        HIout       = ($urandom_range(0, 6) == 0);
        LOin        = ($urandom_range(0, 5) == 0);
        LOout       = ($urandom_range(0, 6) == 0);
        Yin         = ($urandom_range(0, 3) == 0);
        Zin         = ($urandom_range(0, 3) == 0);
        Zhighout    = ($urandom_range(0, 6) == 0);
        Zlowout     = ($urandom_range(0, 6) == 0);
        InPortout   = ($urandom_range(0, 2) == 0);
        alu_op      = 4'($urandom_range(0, 15));
        MDatain     = $urandom;
        inport_data = ($urandom_range(0, 7) == 0) ? 32'd0 :
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) :
                      $urandom;
    endtask

    initial begin
        int nb, nd;
        logic [63:0] e_mul, e_ndiv;
        idle();
        clear = 1;
        cyc();
        cyc();
        idle();
        chk_en = 1;

        sample();
        chk("reset_z", z_out, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_bus", {32'd0, bus_out}, 64'd0);

        IncPC = 1;
        cyc(); cyc(); cyc();
        idle(); PCout = 1;
        sample();
        chk("pc_inc3", {32'd0, bus_out}, 64'd3);
        idle(); drive_in(32'h100); PCin = 1; IncPC = 1;
        cyc();
        idle(); PCout = 1;
        sample();
        chk("pc_load", {32'd0, bus_out}, 64'h100);

        idle(); drive_in(32'h1234); reg_in_en = 1; reg_in_sel = 4'd5;
        cyc();
        idle(); reg_out_en = 1; reg_out_sel = 4'd5; MDRout = 1;
        reg_in_en = 1; reg_in_sel = 4'd9;
        sample();
        chk("prio_r5", {32'd0, bus_out}, 64'h1234);
        cyc();
        idle(); reg_out_en = 1; reg_out_sel = 4'd9;
        sample();
        chk("r9_copy", {32'd0, bus_out}, 64'h1234);

        run_op(32'd7, 32'd5, 4'd1);
        sample();
        chk("sub", z_out, 64'd2);
        run_op(32'h8000_0000, 32'd4, 4'd5);
        sample();
        chk("shra", z_out, 64'h0000_0000_F800_0000);

`ifdef DATAPATH_SIGNED_MULDIV_EN
        e_mul  = 64'hFFFF_FFFF_FFFF_FFFE;
        e_ndiv = 64'hFFFF_FFFE_FFFF_FFF2;
`else
        e_mul  = 64'h0000_0001_FFFF_FFFE;
        e_ndiv = 64'h0000_0002_2492_4916;
`endif
        run_op(32'hFFFF_FFFF, 32'd2, 4'd11);
        watch(36, 5, nb, nd);
        chk("mul_busy_cycles", 64'(nb), 64'd32);
        chk("mul_done_pulses", 64'(nd), 64'd1);
        chk("mul_z", z_out, e_mul);

        run_op(32'd100, 32'd7, 4'd12);
        watch(36, -1, nb, nd);
        chk("div_done_pulses", 64'(nd), 64'd1);
        chk("div_100_7", z_out, {32'd2, 32'd14});
        run_op(-32'd100, 32'd7, 4'd12);
        watch(36, -1, nb, nd);
        chk("div_neg100_7", z_out, e_ndiv);
        run_op(32'd9, 32'd0, 4'd12);
        watch(36, -1, nb, nd);
        chk("div_by_zero", z_out, {32'd9, 32'hFFFF_FFFF});

        run_op(32'd1000, 32'd3, 4'd12);
        for (int i = 0; i < 9; i++) cyc();
        clear = 1;
        cyc();
        idle();
        sample();
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_z", z_out, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        watch(36, -1, nb, nd);
        chk("abort_no_done", 64'(nd), 64'd0);
        run_op(32'd3, 32'd5, 4'd11);
        watch(36, -1, nb, nd);
        chk("mul_after_abort_done", 64'(nd), 64'd1);
        chk("mul_after_abort_z", z_out, 64'd15);

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            cyc();
        end
        idle();
        cyc();
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
